// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, default
// byte width and gap-counter sizing.
package uart_pkg;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned FRAME_CNT_W = 16;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_LAUNCH    = ST_LAUNCH,
      S_WAIT_BUSY = ST_WAIT_BUSY,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_GAP       = ST_GAP
   } arb_state_e;

   // Gap counter holds 0..GAP_TICKS; keep at least one bit when the gap is disabled.
   function automatic int unsigned gap_cnt_w(input int unsigned ticks);
      return (ticks > 0) ? $clog2(ticks + 1) : 1;
   endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on a tie the requester
// that was not served last wins.
module uart_rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   always_comb begin
      gnt_vld_o = |valid_i;
      gnt_idx_o = 1'b0;
      case (valid_i)
         2'b01:   gnt_idx_o = 1'b0;
         2'b10:   gnt_idx_o = 1'b1;
         2'b11:   gnt_idx_o = ~last_i;
         default: gnt_idx_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte requesters, launching one frame
// at a time and enforcing an idle gap of GAP_TICKS baud ticks between frames.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic                   clk_50M,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   input  logic [DATA_W-1:0]      req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [DATA_W-1:0]      req1_data,
   output logic                   req1_ready,
   input  logic                   tick_uart,
   input  logic                   tx_busy,
   output logic                   tx_en,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_owner,
   output logic                   active,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned GAP_W    = gap_cnt_w(GAP_TICKS);
   localparam int unsigned GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

   arb_state_e             state_q,     state_d;
   logic                   tx_en_q,     tx_en_d;
   logic [DATA_W-1:0]      tx_data_q,   tx_data_d;
   logic                   tx_owner_q,  tx_owner_d;
   logic                   last_q,      last_d;
   logic [GAP_W-1:0]       gap_cnt_q,   gap_cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   active_q,    active_d;

   logic gnt_vld;
   logic gnt_idx;
   logic accept;

   uart_rr_arb2 u_arb (
      .valid_i   ({req1_valid, req0_valid}),
      .last_i    (last_q),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   // Ready is only offered from IDLE, so at most one byte is taken per frame.
   assign req0_ready = (state_q == S_IDLE) && gnt_vld && !gnt_idx && req0_valid;
   assign req1_ready = (state_q == S_IDLE) && gnt_vld &&  gnt_idx && req1_valid;
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_owner_d  = tx_owner_q;
      last_d      = last_q;
      gap_cnt_d   = gap_cnt_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_LAUNCH;
               tx_data_d  = gnt_idx ? req1_data : req0_data;
               tx_owner_d = gnt_idx;
               last_d     = gnt_idx;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            // Ticks are only counted once inside GAP, never on the entry cycle.
            if (tick_uart) begin
               if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                  gap_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tx_en_d  = (state_d == S_LAUNCH);
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tx_en_q     <= 1'b0;
         tx_data_q   <= '0;
         tx_owner_q  <= 1'b0;
         last_q      <= 1'b1;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_en_q     <= tx_en_d;
         tx_data_q   <= tx_data_d;
         tx_owner_q  <= tx_owner_d;
         last_q      <= last_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         active_q    <= active_d;
      end
   end

   assign tx_en     = tx_en_q;
   assign tx_data   = tx_data_q;
   assign tx_owner  = tx_owner_q;
   assign active    = active_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a frame-level reference model.
module tb_uart_tx_arbiter;

   localparam int unsigned DW  = 8;
   localparam int unsigned GAP = 2;

   logic          clk_50M = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic [DW-1:0] req0_data,  req1_data;
   logic          req0_ready, req1_ready;
   logic          tick_uart,  tx_busy;
   logic          tx_en;
   logic [DW-1:0] tx_data;
   logic          tx_owner;
   logic          active;
   logic [15:0]   frame_cnt;

   uart_tx_arbiter #(.DATA_W(DW), .GAP_TICKS(GAP)) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tick_uart  (tick_uart),
      .tx_busy    (tx_busy),
      .tx_en      (tx_en),
      .tx_data    (tx_data),
      .tx_owner   (tx_owner),
      .active     (active),
      .frame_cnt  (frame_cnt)
   );

   always #10 clk_50M = ~clk_50M;

   int n_tests = 0;
   int n_fail  = 0;

   // Values sampled on the falling edge of the current cycle.
   logic          s_r0, s_r1, s_en, s_own, s_act, s_v0, s_v1, s_busy, s_tick, s_rst;
   logic [DW-1:0] s_data, s_d0, s_d1;
   logic [15:0]   s_fc;

   // Reference model: one frame in flight at most, plus pending gap ticks.
   bit            m_in_flight, m_launch, m_rise, m_last, m_owner;
   logic [DW-1:0] m_data;
   logic [15:0]   m_frames;
   int            m_gap;

   // Behavioural transmitter used for randomized traffic.
   int tx_dly, tx_len;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_flight = 1'b0;
      m_launch    = 1'b0;
      m_rise      = 1'b0;
      m_last      = 1'b1;
      m_owner     = 1'b0;
      m_data      = '0;
      m_frames    = 16'h0000;
      m_gap       = 0;
   endtask

   task automatic model_step();
      logic e_idle, e_r0, e_r1;
      if (!s_rst) model_reset();
      e_idle = !m_in_flight && (m_gap == 0);
      e_r0   = e_idle && s_v0 && (!s_v1 || m_last);
      e_r1   = e_idle && s_v1 && (!s_v0 || !m_last);
      check_eq("ready0",    32'(s_r0),  32'(e_r0));
      check_eq("ready1",    32'(s_r1),  32'(e_r1));
      check_eq("tx_en",     32'(s_en),  32'(m_launch));
      check_eq("active",    32'(s_act), 32'(!e_idle));
      check_eq("frame_cnt", 32'(s_fc),  32'(m_frames));
      if (m_in_flight) begin
         check_eq("tx_data",  32'(s_data), 32'(m_data));
         check_eq("tx_owner", 32'(s_own),  32'(m_owner));
      end
      if (s_rst) begin
         if (m_gap > 0 && s_tick) m_gap--;
         if (m_in_flight && !m_launch) begin
            if (!m_rise) begin
               if (s_busy) m_rise = 1'b1;
            end else if (!s_busy) begin
               m_frames    = 16'(m_frames + 16'd1);
               m_in_flight = 1'b0;
               m_gap       = GAP;
            end
         end
         m_launch = 1'b0;
         if (e_r0 || e_r1) begin
            m_in_flight = 1'b1;
            m_launch    = 1'b1;
            m_rise      = 1'b0;
            m_owner     = e_r1;
            m_last      = e_r1;
            m_data      = e_r1 ? s_d1 : s_d0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk_50M);
      s_r0 = req0_ready;  s_r1 = req1_ready;  s_en = tx_en;  s_data = tx_data;
      s_own = tx_owner;   s_act = active;     s_fc = frame_cnt;
      s_v0 = req0_valid;  s_v1 = req1_valid;  s_d0 = req0_data; s_d1 = req1_data;
      s_busy = tx_busy;   s_tick = tick_uart; s_rst = rst_n;
      model_step();
      @(posedge clk_50M);
      #1;
   endtask

   task automatic tx_drive();
      if (s_en) begin
         tx_dly = $urandom_range(0, 2);
         tx_len = $urandom_range(1, 4);
      end
      if (tx_dly > 0) begin
         tx_busy = 1'b0;
         tx_dly--;
      end else if (tx_len > 0) begin
         tx_busy = 1'b1;
         tx_len--;
      end else begin
         tx_busy = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tx_busy = 1'b0; tick_uart = 1'b0;
      tx_dly = 0; tx_len = 0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      int n_acc;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = '0; req1_data = '0;
      tick_uart = 1'b0; tx_busy = 1'b0;
      tx_dly = 0; tx_len = 0;
      model_reset();

      // Reset values and a single request from requester 0.
      cycle();
      check_eq("rst_tx_en",  32'(s_en),   32'h0);
      check_eq("rst_data",   32'(s_data), 32'h0);
      check_eq("rst_owner",  32'(s_own),  32'h0);
      check_eq("rst_active", 32'(s_act),  32'h0);
      check_eq("rst_fcnt",   32'(s_fc),   32'h0);
      rst_n = 1'b1;
      cycle();
      req0_valid = 1'b1; req0_data = 8'h55;
      cycle();
      check_eq("single_rdy0", 32'(s_r0), 32'h1);
      req0_valid = 1'b0;
      cycle();
      check_eq("single_en",    32'(s_en),   32'h1);
      check_eq("single_data",  32'(s_data), 32'h55);
      check_eq("single_owner", 32'(s_own),  32'h0);
      cycle();
      tx_busy = 1'b1;
      cycle();
      cycle();
      tx_busy = 1'b0;
      cycle();
      cycle();
      check_eq("single_fcnt", 32'(s_fc), 32'h1);
      tick_uart = 1'b1;
      cycle();
      cycle();
      tick_uart = 1'b0;
      cycle();
      check_eq("single_idle", 32'(s_act), 32'h0);

      // Both requesters held: service must alternate starting with requester 0.
      do_reset();
      req0_valid = 1'b1; req0_data = 8'hA1;
      req1_valid = 1'b1; req1_data = 8'hB2;
      n_acc = 0;
      for (int i = 0; i < 300 && n_acc < 4; i++) begin
         cycle();
         if (s_r0 || s_r1) begin
            check_eq("rr_owner", 32'(s_r1), 32'(n_acc % 2));
            n_acc++;
         end
         tx_drive();
         tick_uart = ($urandom_range(0, 1) == 1);
      end
      check_eq("rr_count", 32'(n_acc), 32'd4);

      // Gap of two ticks; a tick on the busy-fall cycle does not count.
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h11;
      cycle();
      check_eq("gap_first_rdy", 32'(s_r0), 32'h1);
      req0_data = 8'h22;
      cycle();
      tx_busy = 1'b1;
      cycle();
      tx_busy = 1'b0; tick_uart = 1'b1;
      cycle();
      check_eq("gap_fall_rdy", 32'(s_r0), 32'h0);
      tick_uart = 1'b0;
      cycle();
      tick_uart = 1'b1;
      cycle();
      check_eq("gap_tick1_rdy", 32'(s_r0), 32'h0);
      tick_uart = 1'b0;
      cycle();
      tick_uart = 1'b1;
      cycle();
      check_eq("gap_tick2_rdy", 32'(s_r0), 32'h0);
      tick_uart = 1'b0;
      cycle();
      check_eq("gap_after_rdy", 32'(s_r0), 32'h1);

      // Asynchronous reset while waiting for the frame to finish.
      req0_valid = 1'b0;
      cycle();
      tx_busy = 1'b1;
      cycle();
      cycle();
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_tx_en",  32'(tx_en),     32'h0);
      check_eq("arst_data",   32'(tx_data),   32'h0);
      check_eq("arst_owner",  32'(tx_owner),  32'h0);
      check_eq("arst_active", 32'(active),    32'h0);
      check_eq("arst_fcnt",   32'(frame_cnt), 32'h0);
      tx_busy = 1'b0;
      tx_dly = 0; tx_len = 0;
      cycle();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h44;
      req1_valid = 1'b1; req1_data = 8'h66;
      cycle();
      check_eq("arst_rr_rdy0", 32'(s_r0), 32'h1);
      check_eq("arst_rr_rdy1", 32'(s_r1), 32'h0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Frame counter wrap from 0xFFFF.
      for (int i = 0; i < 100 && (m_in_flight || m_gap != 0); i++) begin
         cycle();
         tx_drive();
         tick_uart = ($urandom_range(0, 1) == 1);
      end
      check_eq("wrap_idle_reached", 32'(m_in_flight || m_gap != 0), 32'h0);
      tx_busy = 1'b0; tick_uart = 1'b0;
      force dut.frame_cnt_q = 16'hFFFF;
      m_frames = 16'hFFFF;
      cycle();
      release dut.frame_cnt_q;
      req1_valid = 1'b1; req1_data = 8'h3C;
      for (int i = 0; i < 100 && !(m_frames == 16'h0000 && !m_in_flight); i++) begin
         cycle();
         if (s_r1) req1_valid = 1'b0;
         tx_drive();
         tick_uart = ($urandom_range(0, 1) == 1);
      end
      req1_valid = 1'b0;
      cycle();
      check_eq("wrap_fcnt", 32'(s_fc), 32'h0);

      // Transmitter never raises busy: arbiter parks with no further ready.
      do_reset();
      req0_valid = 1'b1; req0_data = 8'h77;
      cycle();
      check_eq("stuck_accept", 32'(s_r0), 32'h1);
      req1_valid = 1'b1; req1_data = 8'h88;
      for (int i = 0; i < 20; i++) begin
         tick_uart = ($urandom_range(0, 1) == 1);
         cycle();
         check_eq("stuck_no_rdy", 32'(s_r0 | s_r1), 32'h0);
         check_eq("stuck_active", 32'(s_act),       32'h1);
      end

      // Randomized traffic, including requesters withdrawing early.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (s_r0) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req0_data  = DW'($urandom);
         end else if (!req0_valid) begin
            if ($urandom_range(0, 3) == 0) begin
               req0_valid = 1'b1;
               req0_data  = DW'($urandom);
            end
         end else if ($urandom_range(0, 63) == 0) begin
            req0_valid = 1'b0;
         end
         if (s_r1) begin
            req1_valid = ($urandom_range(0, 1) == 1);
            req1_data  = DW'($urandom);
         end else if (!req1_valid) begin
            if ($urandom_range(0, 3) == 0) begin
               req1_valid = 1'b1;
               req1_data  = DW'($urandom);
            end
         end else if ($urandom_range(0, 63) == 0) begin
            req1_valid = 1'b0;
         end
         tx_drive();
         tick_uart = ($urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
